rs232_receiver: RTL
===================

Name: rs232_receiver

Overview:
- UART receive side paired with the existing RS232 transmitter: 8N1, LSB first, idle-high line.
- Synchronises the asynchronous rx pin, validates the start bit at mid-bit, and samples each data bit and the stop bit at mid-bit.
- Delivers each received byte with a one-cycle strobe and flags framing errors.
- Sits between the board RX pin and the calculator's command/operand input logic.

Parameters:
- CLK_DIVIDER, 3125, clk cycles per bit (9600 baud at 30 MHz). Legal range 4..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line from pin, asynchronous to clk, idle high.
- data  out  8  last correctly framed byte; held until the next good frame.
- data_valid  out  1  one-cycle pulse: data updated this cycle.
- frame_error  out  1  one-cycle pulse: stop bit sampled low; data not updated.
- busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE, tick=0, bit_cnt=0, shift register=0.
  - data=8'h00; data_valid, frame_error and busy all 0.
  - Both synchroniser flops and the previous-sample register load 1.
  - Reset mid-frame abandons the frame with no strobe.
- Synchroniser:
  - Two flops, rx -> s1 -> rx_s. All decisions use rx_s.
  - prev register holds rx_s from the previous cycle.
  - Fixed 2-cycle input latency.
- Counters:
  - HALF = CLK_DIVIDER/2, integer floor.
  - tick is 16 bits; bit_cnt is 4 bits.
- IDLE:
  - tick=0.
  - Falling edge (prev=1, rx_s=0) -> START.
  - A line held continuously low never triggers; it needs a 1->0 edge.
- START:
  - tick increments each cycle.
  - When tick==HALF-1: if rx_s=0 -> DATA, tick=0, bit_cnt=0. If rx_s=1 -> IDLE as a glitch (no strobe, no error).
- DATA:
  - tick increments; when tick==CLK_DIVIDER-1 the cycle is a sample point.
  - At each sample point: shift register takes rx_s in at the MSB and shifts right (LSB first on the wire), tick=0, bit_cnt+1.
  - After the 8th sample -> STOP, tick=0.
- STOP:
  - Sample point when tick==CLK_DIVIDER-1.
  - rx_s=1: data<=shift register, data_valid=1 for exactly the next cycle.
  - rx_s=0: frame_error=1 for exactly the next cycle; data unchanged.
  - Either way -> IDLE the cycle after the sample. No wait for end of stop bit, so back-to-back frames are caught.
- Strobes:
  - data_valid and frame_error are never high together.
  - Each is high for exactly one cycle per frame.
- busy is 1 in START, DATA and STOP; 0 in IDLE.
- No flow control. A byte not consumed is overwritten by the next good frame (no overrun flag).
- Illegal state encoding -> IDLE.

Test Plan (bench uses CLK_DIVIDER=16, 16 clk per bit unless stated):
- Reset state: hold rst 3 cycles with rx=1 -> data=00, data_valid=0, frame_error=0, busy=0.
- Single byte: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one data_valid pulse, data=8'hA5. Pulse occurs 2+8+16*9 cycles (±1) after the start edge. busy falls in the same cycle.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no idle gap -> three data_valid pulses carrying 00, FF, 55 in order; no frame_error.
- Glitch rejection: drive rx low for 4 cycles then high -> no strobe; busy high at most 8+2 cycles, then 0; the next valid frame 0x3C is received correctly.
- Framing error: send 0x81 with stop bit 0 and hold rx low 40 cycles, then high -> one frame_error pulse; data keeps its previous value; no retrigger while low. A following 0x7E frame then gives data_valid with data=7E.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 0xC3 -> no strobe, busy=0, data=00. A subsequent 0x12 frame is received correctly.

Source files
------------

// File: rtl/rs232_receiver_if.sv
// rtl/rs232_receiver_if.sv - serial RX line and received-byte outputs of the UART receiver
interface rs232_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport master (
    input  rx,
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/rs232_receiver.sv
// rtl/rs232_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing-error strobe
module rs232_receiver #(
  parameter int CLK_DIVIDER = 3125
) (
  input  logic                  clk,
  input  logic                  rst,
  rs232_receiver_if.master      bus
);

  localparam int          HALF    = CLK_DIVIDER / 2;
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLK_DIVIDER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] tick;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        s1;
  logic        rx_s;
  logic        prev;
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic        frame_error_q;
  logic        busy_q;

  assign bus.data        = data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;

  // Synchroniser and edge-detect history reset high so a quiet line never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b1;
      rx_s          <= 1'b1;
      prev          <= 1'b1;
      state         <= IDLE;
      tick          <= 16'd0;
      bit_cnt       <= 4'd0;
      shreg         <= 8'h00;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      s1            <= bus.rx;
      rx_s          <= s1;
      prev          <= rx_s;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      case (state)
        IDLE: begin
          tick <= 16'd0;
          if (prev && !rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (tick == HALF_M1) begin
            tick    <= 16'd0;
            bit_cnt <= 4'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end

        DATA: begin
          if (tick == BIT_M1) begin
            shreg   <= {rx_s, shreg[7:1]};
            tick    <= 16'd0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= STOP;
            end
          end else begin
            tick <= tick + 16'd1;
          end
        end

        STOP: begin
          // Return to IDLE at the stop sample itself so a start bit right after it is not missed.
          if (tick == BIT_M1) begin
            if (rx_s) begin
              data_q       <= shreg;
              data_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
            state  <= IDLE;
            busy_q <= 1'b0;
            tick   <= 16'd0;
          end else begin
            tick <= tick + 16'd1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          tick   <= 16'd0;
        end
      endcase
    end
  end

endmodule
